// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory for the single-cycle RV32 core.
// Accepts one load or store at a time, holds the core with stall for
// WAIT_STATES+1 cycles, then spends one RESP cycle presenting the result.
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   mem_addr        byte address; word index is mem_addr[31:2]
//   wdata           store data
//   mem_access_mode 00 none, 01 byte, 10 half, 11 word store
//   rd_en           load request (ignored when a store is requested)
//   rdata           registered load data, right-justified by mem_addr[1:0]
//   rvalid          one-cycle pulse in RESP after a load
//   stall           combinational hold to the core
//   err             one-cycle pulse after a misaligned or out-of-range request
module dmem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  mem_access_mode,
    input  logic        rd_en,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        stall,
    output logic        err
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam logic [3:0] CntInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // Captured request; only the in-range address bits are kept.
    logic [IdxW+1:0] addr_q;
    logic [31:0]     wdata_q;
    logic [1:0]      mode_q;
    logic            is_rd_q;

    logic [31:0] mem [DEPTH];

    logic wr_req, rd_req, misaligned, oor, good_req, bad_req;

    always_comb begin
        wr_req     = (mem_access_mode != 2'b00);
        rd_req     = rd_en & ~wr_req;
        misaligned = ((mem_access_mode == 2'b10) & mem_addr[0]) |
                     ((mem_access_mode == 2'b11) & (mem_addr[1:0] != 2'b00));
        oor        = ({2'b00, mem_addr[31:2]} >= DEPTH);
        good_req   = (wr_req | rd_req) & ~misaligned & ~oor;
        bad_req    = (wr_req | rd_req) & (misaligned | oor);
    end

    // With zero wait states the access happens on the accept edge itself,
    // straight from the live inputs; otherwise from the captured copy.
    logic            acc_now, do_access, do_write;
    logic [IdxW+1:0] acc_addr;
    logic [31:0]     acc_wdata;
    logic [1:0]      acc_mode;
    logic            acc_rd;
    logic [IdxW-1:0] acc_idx;
    logic [3:0]      lane_we;
    logic [31:0]     wbytes;
    logic [31:0]     rd_word;

    always_comb begin
        acc_now   = (state_q == StIdle) & good_req & (WAIT_STATES == 0);
        do_access = rst_n & (acc_now | ((state_q == StBusy) & (cnt_q == 4'd0)));
        acc_addr  = acc_now ? mem_addr[IdxW+1:0] : addr_q;
        acc_wdata = acc_now ? wdata : wdata_q;
        acc_mode  = acc_now ? mem_access_mode : mode_q;
        acc_rd    = acc_now ? rd_req : is_rd_q;
        acc_idx   = acc_addr[IdxW+1:2];
        do_write  = do_access & ~acc_rd;
        rd_word   = mem[acc_idx];

        lane_we = 4'b0000;
        wbytes  = acc_wdata;
        unique case (acc_mode)
            2'b01: begin
                lane_we = 4'b0001 << acc_addr[1:0];
                wbytes  = {4{acc_wdata[7:0]}};
            end
            2'b10: begin
                lane_we = acc_addr[1] ? 4'b1100 : 4'b0011;
                wbytes  = {2{acc_wdata[15:0]}};
            end
            2'b11: lane_we = 4'b1111;
            default: lane_we = 4'b0000;
        endcase
    end

    // Array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_we[i]) mem[acc_idx][8*i +: 8] <= wbytes[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (good_req) begin
                    state_d = (WAIT_STATES == 0) ? StResp : StBusy;
                    cnt_d   = CntInit;
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) state_d = StResp;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            mode_q  <= 2'b00;
            is_rd_q <= 1'b0;
            rdata   <= 32'd0;
            rvalid  <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if ((state_q == StIdle) && good_req) begin
                addr_q  <= mem_addr[IdxW+1:0];
                wdata_q <= wdata;
                mode_q  <= mem_access_mode;
                is_rd_q <= rd_req;
            end
            if (do_access && acc_rd) rdata <= rd_word >> {acc_addr[1:0], 3'b000};
            rvalid <= do_access & acc_rd;
            err    <= (state_q == StIdle) & bad_req;
        end
    end

    // Forced low in reset so a dropped access releases the core at once.
    assign stall = rst_n & (((state_q == StIdle) & good_req) | (state_q == StBusy));

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Two instances: A (WAIT_STATES=2,
// DEPTH=1024) and B (WAIT_STATES=0, DEPTH=64), each with its own inputs,
// checked against a byte-level memory model and a cycle-count expectation.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s   [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [1:0]  mode_s  [2];
    logic        rden_s  [2];

    logic [31:0] rdata_a, rdata_b;
    logic        rvalid_a, rvalid_b, stall_a, stall_b, err_a, err_b;

    dmem_responder #(.DEPTH(1024), .WAIT_STATES(2)) u_dut_a (
        .clk             (clk),
        .rst_n           (rst_s[0]),
        .mem_addr        (addr_s[0]),
        .wdata           (wdata_s[0]),
        .mem_access_mode (mode_s[0]),
        .rd_en           (rden_s[0]),
        .rdata           (rdata_a),
        .rvalid          (rvalid_a),
        .stall           (stall_a),
        .err             (err_a)
    );

    dmem_responder #(.DEPTH(64), .WAIT_STATES(0)) u_dut_b (
        .clk             (clk),
        .rst_n           (rst_s[1]),
        .mem_addr        (addr_s[1]),
        .wdata           (wdata_s[1]),
        .mem_access_mode (mode_s[1]),
        .rd_en           (rden_s[1]),
        .rdata           (rdata_b),
        .rvalid          (rvalid_b),
        .stall           (stall_b),
        .err             (err_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mdl [2][1024];
    logic [31:0] exp_rdata [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic f_stall(input int s);
        return (s == 0) ? stall_a : stall_b;
    endfunction
    function automatic logic f_rvalid(input int s);
        return (s == 0) ? rvalid_a : rvalid_b;
    endfunction
    function automatic logic f_err(input int s);
        return (s == 0) ? err_a : err_b;
    endfunction
    function automatic logic [31:0] f_rdata(input int s);
        return (s == 0) ? rdata_a : rdata_b;
    endfunction

    task automatic idle_inputs(input int s);
        addr_s[s]  = 32'd0;
        wdata_s[s] = 32'd0;
        mode_s[s]  = 2'b00;
        rden_s[s]  = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after RESP.
    task automatic do_req(input int s, input logic [1:0] m, input logic r,
                          input logic [31:0] a, input logic [31:0] d);
        int unsigned depth;
        int          ws;
        int          cnt;
        logic        wr, rd, bad;
        depth = (s == 0) ? 1024 : 64;
        ws    = (s == 0) ? 2 : 0;
        wr    = (m != 2'b00);
        rd    = r && !wr;
        bad   = (m == 2'b10 && a[0]) || (m == 2'b11 && a[1:0] != 2'b00) ||
                ((a >> 2) >= depth);
        mode_s[s]  = m;
        rden_s[s]  = r;
        addr_s[s]  = a;
        wdata_s[s] = d;
        #1;
        if (bad) begin
            check("bad_stall", 32'(f_stall(s)), 32'd0);
            @(negedge clk);
            check("bad_err", 32'(f_err(s)), 32'd1);
            check("bad_rvalid", 32'(f_rvalid(s)), 32'd0);
            check("bad_rdata_kept", f_rdata(s), exp_rdata[s]);
            idle_inputs(s);
            @(negedge clk);
            check("bad_err_pulse", 32'(f_err(s)), 32'd0);
            return;
        end
        check("acc_stall", 32'(f_stall(s)), 32'd1);
        cnt = 1;
        @(negedge clk);
        while (f_stall(s) && cnt < 40) begin
            cnt++;
            // Inputs seen during the wait must not matter.
            addr_s[s]  = $urandom;
            wdata_s[s] = $urandom;
            mode_s[s]  = 2'($urandom);
            rden_s[s]  = 1'($urandom);
            @(negedge clk);
        end
        idle_inputs(s);
        check("stall_cycles", 32'(cnt), 32'(ws + 1));
        if (wr) begin
            case (m)
                2'b01:   mdl[s][a[31:2]][8*a[1:0] +: 8] = d[7:0];
                2'b10:   mdl[s][a[31:2]][16*a[1] +: 16] = d[15:0];
                default: mdl[s][a[31:2]] = d;
            endcase
        end else begin
            exp_rdata[s] = mdl[s][a[31:2]] >> (8 * a[1:0]);
        end
        check("resp_rvalid", 32'(f_rvalid(s)), 32'(rd));
        check("resp_rdata", f_rdata(s), exp_rdata[s]);
        check("resp_err", 32'(f_err(s)), 32'd0);
        @(negedge clk);
        check("rvalid_pulse", 32'(f_rvalid(s)), 32'd0);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst_s[s] = 1'b0;
            idle_inputs(s);
            exp_rdata[s] = 32'd0;
            for (int w = 0; w < 1024; w++) mdl[s][w] = 32'd0;
        end
        repeat (2) @(negedge clk);
        check("rst_stall_a", 32'(stall_a), 32'd0);
        check("rst_rdata_a", rdata_a, 32'd0);
        check("rst_rvalid_b", 32'(rvalid_b), 32'd0);
        check("rst_err_b", 32'(err_b), 32'd0);
        rst_s[0] = 1'b1;
        rst_s[1] = 1'b1;
        @(negedge clk);

        // Give every word used below known contents.
        for (int w = 0; w < 32; w++) begin
            do_req(0, 2'b11, 1'b0, 32'(4 * w), 32'd0);
            do_req(1, 2'b11, 1'b0, 32'(4 * w), 32'd0);
        end

        // Directed cases on A.
        do_req(0, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF);
        do_req(0, 2'b00, 1'b1, 32'h10, 32'h0);
        check("plan_word", rdata_a, 32'hDEADBEEF);
        do_req(0, 2'b01, 1'b0, 32'h11, 32'h000000AB);
        do_req(0, 2'b10, 1'b0, 32'h12, 32'h00001234);
        do_req(0, 2'b00, 1'b1, 32'h10, 32'h0);
        check("plan_merge", rdata_a, 32'h1234ABEF);
        do_req(0, 2'b00, 1'b1, 32'h13, 32'h0);
        check("plan_shift", rdata_a, 32'h00000012);
        do_req(0, 2'b11, 1'b0, 32'h20, 32'h87654321);
        do_req(0, 2'b10, 1'b0, 32'h21, 32'hFFFFFFFF);
        do_req(0, 2'b11, 1'b0, 32'h22, 32'hFFFFFFFF);
        do_req(0, 2'b00, 1'b1, 32'h20, 32'h0);
        check("plan_misalign_kept", rdata_a, 32'h87654321);
        do_req(0, 2'b11, 1'b0, 32'd4096, 32'h11111111);
        do_req(0, 2'b00, 1'b1, 32'd4096, 32'h0);
        do_req(0, 2'b11, 1'b1, 32'h14, 32'hA5A5A5A5);  // store wins over rd_en

        // Reset in BUSY drops the store.
        mode_s[0]  = 2'b11;
        addr_s[0]  = 32'h30;
        wdata_s[0] = 32'h55555555;
        @(posedge clk);
        @(negedge clk);
        check("busy_stall", 32'(stall_a), 32'd1);
        rst_s[0] = 1'b0;
        #1;
        check("rst_drops_stall", 32'(stall_a), 32'd0);
        idle_inputs(0);
        repeat (2) @(negedge clk);
        rst_s[0] = 1'b1;
        exp_rdata[0] = 32'd0;
        @(negedge clk);
        do_req(0, 2'b00, 1'b1, 32'h30, 32'h0);
        check("plan_rst_nowrite", rdata_a, 32'h00000000);

        // Zero-wait-state instance, back-to-back.
        do_req(1, 2'b11, 1'b0, 32'h40, 32'hCAFEF00D);
        do_req(1, 2'b00, 1'b1, 32'h40, 32'h0);
        check("plan_ws0", rdata_b, 32'hCAFEF00D);
        do_req(1, 2'b01, 1'b0, 32'd256, 32'h1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            int          s;
            logic [1:0]  m;
            logic        r;
            logic [31:0] a;
            s = int'($urandom_range(0, 1));
            m = 2'($urandom_range(0, 3));
            r = (m == 2'b00) ? 1'b1 : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                a = (s == 0) ? 32'd4096 + $urandom_range(0, 255) : 32'd256 + $urandom;
            else
                a = 32'($urandom_range(0, 127));
            if (a < 32'd256 && s == 1 && a >= 32'd256) a = 32'd0;
            do_req(s, m, r, a, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish, expected $finish");
        $fatal(1);
    end

endmodule
